pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program counter for the instruction-fetch stage; it replaces the bare PC register. It holds the fetch address and steps it sequentially by 4, or by 2 for compressed instructions. It accepts branch/jump redirects and trap vectors, supports stall and debug halt/resume, detects misaligned redirect targets, and counts issued fetches.

Parameters:
XLEN, 64, address width in bits
RESET_VECTOR, 64'h0000_0000_0000_0000, PC value loaded on reset (truncated to XLEN)
SUPPORT_C, 0, 1 = compressed instructions enabled (2-byte alignment), 0 = 4-byte alignment only
COUNT_W, 32, width of fetch counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hold PC (pipeline backpressure)
is_compressed  input  1  current instruction is 16-bit; ignored when SUPPORT_C=0
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  XLEN  branch/jump destination
trap_valid  input  1  exception/interrupt entry
trap_vector  input  XLEN  trap handler address
halt_req  input  1  debug halt request
resume  input  1  debug resume
pc  output  XLEN  current fetch address
pc_valid  output  1  pc is a live fetch request
misaligned_fault  output  1  misaligned redirect detected, level until trap
fault_addr  output  XLEN  offending redirect target
fetch_count  output  COUNT_W  number of advancing fetch cycles, wraps

Behaviour:
- Reset (async assert, any state): pc=RESET_VECTOR, state=BOOT, pc_valid=0, misaligned_fault=0, fault_addr=0, fetch_count=0. Outputs update immediately on assertion, without waiting for a clock edge.
- States: BOOT, RUN, HALTED, FAULT. All outputs are registered; state and pc update on the rising clk edge.
- BOOT: first edge with rst low -> RUN. pc is unchanged, so the first fetch is at RESET_VECTOR. Other inputs are ignored in BOOT.
- pc_valid = 1 only in RUN.
- Per-edge priority in RUN: trap > redirect > halt_req > stall > sequential step.
  - trap_valid: pc = trap_vector with low 2 bits cleared; state stays RUN.
  - redirect_valid, aligned target: pc = redirect_target.
  - redirect_valid, misaligned target: target[1:0]!=0 when SUPPORT_C=0, target[0]!=0 when SUPPORT_C=1. pc holds, fault_addr=target, misaligned_fault=1, state -> FAULT.
  - halt_req: pc holds, state -> HALTED.
  - stall: pc holds.
  - Otherwise: pc += 2 if SUPPORT_C && is_compressed, else pc += 4.
- Arithmetic is modulo 2^XLEN. pc = 2^XLEN-4 with step 4 wraps to 0, with no flag.
- stall never blocks a trap or a redirect; a control transfer overrides a stall.
- HALTED: trap_valid -> pc=aligned vector, state -> RUN. Else redirect_valid -> pc updated (same alignment check; misaligned -> FAULT), state stays HALTED. Else resume -> RUN. halt_req and resume asserted together: stay HALTED.
- FAULT: pc holds, pc_valid=0. Only trap_valid exits: pc=aligned vector, misaligned_fault=0, state -> RUN. fault_addr retains its value until the next fault or reset.
- fetch_count increments on every RUN-state edge where pc steps sequentially or takes a trap or an aligned redirect. It does not increment on stall, halt entry, or fault entry. It wraps at 2^COUNT_W.
- No combinational path from inputs to outputs.

Test Plan:
- Reset/boot: assert rst mid-run with pc=0x1234 -> pc=0 immediately, pc_valid=0. Release rst -> pc_valid=1 after 1 edge, pc=0. Three more edges -> pc=0xC, fetch_count=3.
- Priority: in RUN assert stall+redirect_valid(0x8000)+trap_valid(0x100F) together -> pc=0x100C, fetch_count+1. Next edge, stall only -> pc holds 0x100C, count unchanged.
- Misalignment (SUPPORT_C=0): redirect_target=0x2002 -> misaligned_fault=1, fault_addr=0x2002, pc_valid=0, pc held. Then trap_vector=0x40 -> pc=0x40, RUN, fault cleared, fault_addr still 0x2002.
- Compressed (SUPPORT_C=1): pc=0x10 with is_compressed=1,0,1 over three edges -> pc=0x12, 0x16, 0x18. Redirect to 0x2002 accepted with no fault.
- Halt: halt_req at pc=0x20 -> HALTED, pc_valid=0. Redirect 0x300 while halted -> pc=0x300, still halted. resume -> RUN, next step pc=0x304.
- Wrap: XLEN=64, redirect to 0xFFFF_FFFF_FFFF_FFFC then one step -> pc=0. COUNT_W=4 after 16 advances -> fetch_count=0.

Source files
------------

// File: rtl/pc_unit.sv
// Instruction-fetch program counter: sequential stepping, trap/redirect control
// transfers, debug halt/resume, misaligned-target detection and a fetch counter.
module pc_unit #(
  parameter int          XLEN         = 64,
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
  parameter bit          SUPPORT_C    = 1'b0,
  parameter int          COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               is_compressed,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_vector,
  input  logic               halt_req,
  input  logic               resume,
  output logic [XLEN-1:0]    pc,
  output logic               pc_valid,
  output logic               misaligned_fault,
  output logic [XLEN-1:0]    fault_addr,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VECTOR);

  state_t             state_reg, state_next;
  logic [XLEN-1:0]    pc_reg, pc_next;
  logic               valid_reg, valid_next;
  logic               fault_reg, fault_next;
  logic [XLEN-1:0]    fault_addr_reg, fault_addr_next;
  logic [COUNT_W-1:0] count_reg, count_next;

  logic [XLEN-1:0]    trap_aligned;
  logic [XLEN-1:0]    step_amount;
  logic [XLEN-1:0]    pc_seq;
  logic               target_misaligned;
  logic               advance;

  // Trap handlers always start on a 4-byte boundary, regardless of SUPPORT_C.
  assign trap_aligned = trap_vector & ~XLEN'(3);
  assign step_amount  = (SUPPORT_C && is_compressed) ? XLEN'(2) : XLEN'(4);
  assign pc_seq       = pc_reg + step_amount;

  generate
    if (SUPPORT_C) begin : g_align_c
      assign target_misaligned = redirect_target[0];
    end else begin : g_align_w
      assign target_misaligned = |redirect_target[1:0];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    fault_next      = fault_reg;
    fault_addr_next = fault_addr_reg;
    advance         = 1'b0;

    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end

      RUN: begin
        if (trap_valid) begin
          pc_next = trap_aligned;
          advance = 1'b1;
        end else if (redirect_valid) begin
          if (target_misaligned) begin
            fault_next      = 1'b1;
            fault_addr_next = redirect_target;
            state_next      = FAULT;
          end else begin
            pc_next = redirect_target;
            advance = 1'b1;
          end
        end else if (halt_req) begin
          state_next = HALTED;
        end else if (!stall) begin
          pc_next = pc_seq;
          advance = 1'b1;
        end
      end

      HALTED: begin
        if (trap_valid) begin
          pc_next    = trap_aligned;
          state_next = RUN;
        end else if (redirect_valid) begin
          if (target_misaligned) begin
            fault_next      = 1'b1;
            fault_addr_next = redirect_target;
            state_next      = FAULT;
          end else begin
            pc_next = redirect_target;
          end
        end else if (resume && !halt_req) begin
          state_next = RUN;
        end
      end

      default: begin
        // FAULT: only a trap recovers; fault_addr is kept for the handler.
        if (trap_valid) begin
          pc_next    = trap_aligned;
          fault_next = 1'b0;
          state_next = RUN;
        end
      end
    endcase

    count_next = count_reg + (advance ? COUNT_W'(1) : COUNT_W'(0));
    valid_next = (state_next == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_PC;
      valid_reg      <= 1'b0;
      fault_reg      <= 1'b0;
      fault_addr_reg <= '0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      valid_reg      <= valid_next;
      fault_reg      <= fault_next;
      fault_addr_reg <= fault_addr_next;
      count_reg      <= count_next;
    end
  end

  assign pc               = pc_reg;
  assign pc_valid         = valid_reg;
  assign misaligned_fault = fault_reg;
  assign fault_addr       = fault_addr_reg;
  assign fetch_count      = count_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a 4-byte-only instance (4-bit counter) and a compressed
// instance (8-bit counter) share one stimulus stream and a behavioural model.
module tb_pc_unit;

  typedef struct {
    bit          stall;
    bit          comp;
    bit          rv;
    logic [63:0] rt;
    bit          tv;
    logic [63:0] tt;
    bit          halt;
    bit          resume;
  } in_t;

  typedef struct {
    in_t         i;
    logic [63:0] pc;
    bit          valid;
    bit          fault;
    logic [63:0] faddr;
    int          cnt;
  } vec_t;

  // mode: 0 boot, 1 running, 2 halted, 3 faulted
  typedef struct {
    int          mode;
    logic [63:0] pc;
    bit          fault;
    logic [63:0] faddr;
    int unsigned cnt;
  } model_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, comp, rv, tv, halt, resume;
  logic [63:0] rt, tt;

  logic [63:0] pc0, faddr0, pc1, faddr1;
  logic        valid0, fault0, valid1, fault1;
  logic [3:0]  cnt0;
  logic [7:0]  cnt1;

  int n_pass = 0;
  int n_total = 0;
  in_t    cur;
  model_t m0, m1;
  vec_t   tbl[19];

  always #5 clk = ~clk;

  pc_unit #(.XLEN(64), .RESET_VECTOR(64'h0), .SUPPORT_C(1'b0), .COUNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .is_compressed(comp),
    .redirect_valid(rv), .redirect_target(rt), .trap_valid(tv), .trap_vector(tt),
    .halt_req(halt), .resume(resume), .pc(pc0), .pc_valid(valid0),
    .misaligned_fault(fault0), .fault_addr(faddr0), .fetch_count(cnt0)
  );

  pc_unit #(.XLEN(64), .RESET_VECTOR(64'h0), .SUPPORT_C(1'b1), .COUNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .is_compressed(comp),
    .redirect_valid(rv), .redirect_target(rt), .trap_valid(tv), .trap_vector(tt),
    .halt_req(halt), .resume(resume), .pc(pc1), .pc_valid(valid1),
    .misaligned_fault(fault1), .fault_addr(faddr1), .fetch_count(cnt1)
  );

  function automatic model_t mreset();
    model_t m;
    m.mode = 0; m.pc = 64'h0; m.fault = 1'b0; m.faddr = 64'h0; m.cnt = 0;
    return m;
  endfunction

  // One clock edge of the spec's rules, in plain arithmetic.
  function automatic model_t mstep(model_t m, in_t x, bit supc, int cw);
    model_t      n = m;
    logic [63:0] vec = x.tt - (x.tt % 4);
    bit          bad = supc ? (x.rt % 2 != 0) : (x.rt % 4 != 0);
    if (m.mode == 0) begin
      n.mode = 1;
    end else if (m.mode == 1) begin
      if (x.tv) begin n.pc = vec; n.cnt++; end
      else if (x.rv && bad) begin n.mode = 3; n.fault = 1; n.faddr = x.rt; end
      else if (x.rv) begin n.pc = x.rt; n.cnt++; end
      else if (x.halt) n.mode = 2;
      else if (!x.stall) begin n.pc = m.pc + ((supc && x.comp) ? 2 : 4); n.cnt++; end
    end else if (m.mode == 2) begin
      if (x.tv) begin n.pc = vec; n.mode = 1; end
      else if (x.rv && bad) begin n.mode = 3; n.fault = 1; n.faddr = x.rt; end
      else if (x.rv) n.pc = x.rt;
      else if (x.resume && !x.halt) n.mode = 1;
    end else begin
      if (x.tv) begin n.pc = vec; n.fault = 0; n.mode = 1; end
    end
    n.cnt = n.cnt % (1 << cw);
    return n;
  endfunction

  function automatic in_t idle();
    in_t x;
    x.stall = 0; x.comp = 0; x.rv = 0; x.rt = 0; x.tv = 0; x.tt = 0; x.halt = 0; x.resume = 0;
    return x;
  endfunction

  function automatic vec_t mk(bit st, bit hl, bit rs, bit rvv, logic [63:0] rtt, bit tvv,
                              logic [63:0] ttt, logic [63:0] epc, bit ev, bit ef,
                              logic [63:0] efa, int ec);
    vec_t v;
    v.i = idle();
    v.i.stall = st; v.i.halt = hl; v.i.resume = rs;
    v.i.rv = rvv; v.i.rt = rtt; v.i.tv = tvv; v.i.tt = ttt;
    v.pc = epc; v.valid = ev; v.fault = ef; v.faddr = efa; v.cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %h, expected %h", name, act, req);
    else n_pass++;
  endtask

  task automatic apply(input in_t x);
    cur = x;
    stall = x.stall; comp = x.comp; rv = x.rv; rt = x.rt;
    tv = x.tv; tt = x.tt; halt = x.halt; resume = x.resume;
  endtask

  task automatic tick();
    model_t n0, n1;
    n0 = mstep(m0, cur, 1'b0, 4);
    n1 = mstep(m1, cur, 1'b1, 8);
    @(posedge clk);
    #1;
    m0 = n0;
    m1 = n1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " dut0.pc"},    pc0,                 m0.pc);
    check({tag, " dut0.valid"}, 64'(valid0),         64'(m0.mode == 1));
    check({tag, " dut0.fault"}, 64'(fault0),         64'(m0.fault));
    check({tag, " dut0.faddr"}, faddr0,              m0.faddr);
    check({tag, " dut0.count"}, 64'(cnt0),           64'(m0.cnt));
    check({tag, " dut1.pc"},    pc1,                 m1.pc);
    check({tag, " dut1.valid"}, 64'(valid1),         64'(m1.mode == 1));
    check({tag, " dut1.fault"}, 64'(fault1),         64'(m1.fault));
    check({tag, " dut1.faddr"}, faddr1,              m1.faddr);
    check({tag, " dut1.count"}, 64'(cnt1),           64'(m1.cnt));
  endtask

  // Asserted between edges so the clear must come from the asynchronous path.
  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    m0 = mreset();
    m1 = mreset();
    check({tag, " rst.pc"},    pc0, 64'h0);
    check({tag, " rst.valid"}, 64'(valid0), 64'h0);
    check({tag, " rst.count"}, 64'(cnt0), 64'h0);
    compare_model({tag, " rst"});
    #1 rst = 1'b0;
  endtask

  initial begin
    in_t x;
    rst = 1'b1;
    apply(idle());
    m0 = mreset();
    m1 = mreset();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    rst = 1'b0;

    tick();
    check("boot pc", pc0, 64'h0);
    check("boot valid", 64'(valid0), 64'h1);
    x = idle(); x.rv = 1; x.rt = 64'h1234;
    apply(x);
    tick();
    check("pre-reset pc", pc0, 64'h1234);
    apply(idle());
    async_reset("midrun");

    //          st hl rs rv rt                      tv tt          pc                     v f faddr    cnt
    tbl[0]  = mk(0, 0, 0, 0, 64'h0,                  0, 64'h0,    64'h0,                 1, 0, 64'h0,    0);
    tbl[1]  = mk(0, 0, 0, 0, 64'h0,                  0, 64'h0,    64'h4,                 1, 0, 64'h0,    1);
    tbl[2]  = mk(0, 0, 0, 0, 64'h0,                  0, 64'h0,    64'h8,                 1, 0, 64'h0,    2);
    tbl[3]  = mk(0, 0, 0, 0, 64'h0,                  0, 64'h0,    64'hC,                 1, 0, 64'h0,    3);
    tbl[4]  = mk(1, 0, 0, 1, 64'h8000,               1, 64'h100F, 64'h100C,              1, 0, 64'h0,    4);
    tbl[5]  = mk(1, 0, 0, 0, 64'h0,                  0, 64'h0,    64'h100C,              1, 0, 64'h0,    4);
    tbl[6]  = mk(0, 0, 0, 1, 64'h2002,               0, 64'h0,    64'h100C,              0, 1, 64'h2002, 4);
    tbl[7]  = mk(0, 0, 0, 1, 64'h500,                0, 64'h0,    64'h100C,              0, 1, 64'h2002, 4);
    tbl[8]  = mk(0, 0, 0, 0, 64'h0,                  1, 64'h40,   64'h40,                1, 0, 64'h2002, 4);
    tbl[9]  = mk(0, 0, 0, 1, 64'h20,                 0, 64'h0,    64'h20,                1, 0, 64'h2002, 5);
    tbl[10] = mk(0, 1, 0, 0, 64'h0,                  0, 64'h0,    64'h20,                0, 0, 64'h2002, 5);
    tbl[11] = mk(0, 0, 0, 1, 64'h300,                0, 64'h0,    64'h300,               0, 0, 64'h2002, 5);
    tbl[12] = mk(0, 1, 1, 0, 64'h0,                  0, 64'h0,    64'h300,               0, 0, 64'h2002, 5);
    tbl[13] = mk(0, 0, 1, 0, 64'h0,                  0, 64'h0,    64'h300,               1, 0, 64'h2002, 5);
    tbl[14] = mk(0, 0, 0, 0, 64'h0,                  0, 64'h0,    64'h304,               1, 0, 64'h2002, 6);
    tbl[15] = mk(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,   64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h2002, 7);
    tbl[16] = mk(0, 0, 0, 0, 64'h0,                  0, 64'h0,    64'h0,                 1, 0, 64'h2002, 8);
    tbl[17] = mk(1, 1, 0, 0, 64'h0,                  0, 64'h0,    64'h0,                 0, 0, 64'h2002, 8);
    tbl[18] = mk(0, 0, 0, 0, 64'h0,                  1, 64'h7,    64'h4,                 1, 0, 64'h2002, 8);

    for (int k = 0; k < 19; k++) begin
      apply(tbl[k].i);
      tick();
      $display("vec %0d: pc=%h valid=%0b fault=%0b faddr=%h count=%0d", k, pc0, valid0, fault0, faddr0, cnt0);
      check($sformatf("vec%0d pc", k),    pc0,          tbl[k].pc);
      check($sformatf("vec%0d valid", k), 64'(valid0),  64'(tbl[k].valid));
      check($sformatf("vec%0d fault", k), 64'(fault0),  64'(tbl[k].fault));
      check($sformatf("vec%0d faddr", k), faddr0,       tbl[k].faddr);
      check($sformatf("vec%0d count", k), 64'(cnt0),    64'(tbl[k].cnt));
      compare_model($sformatf("vec%0d", k));
    end

    // Eight more advances bring the 4-bit counter to 16 fetches, i.e. zero.
    apply(idle());
    for (int k = 0; k < 8; k++) begin
      tick();
      compare_model($sformatf("wrap%0d", k));
    end
    $display("count wrap: pc=%h count=%0d", pc0, cnt0);
    check("count wrap", 64'(cnt0), 64'h0);
    check("count wrap pc", pc0, 64'h24);

    x = idle(); x.rv = 1; x.rt = 64'h10;
    apply(x);
    tick();
    for (int k = 0; k < 3; k++) begin
      x = idle(); x.comp = (k != 1);
      apply(x);
      tick();
      $display("compressed step %0d: pc1=%h pc0=%h", k, pc1, pc0);
      compare_model($sformatf("comp%0d", k));
    end
    check("comp pc1", pc1, 64'h18);
    check("comp pc0", pc0, 64'h1C);
    x = idle(); x.rv = 1; x.rt = 64'h2002;
    apply(x);
    tick();
    $display("redirect 2002: pc1=%h fault1=%0b fault0=%0b", pc1, fault1, fault0);
    check("c-redirect pc1", pc1, 64'h2002);
    check("c-redirect fault1", 64'(fault1), 64'h0);
    check("c-redirect fault0", 64'(fault0), 64'h1);
    compare_model("c-redirect");
    x = idle(); x.tv = 1; x.tt = 64'h40;
    apply(x);
    tick();
    compare_model("recover");

    for (int k = 0; k < 400; k++) begin
      x = idle();
      x.stall  = ($urandom_range(3) == 0);
      x.comp   = $urandom_range(1);
      x.rv     = ($urandom_range(5) == 0);
      x.rt     = {$urandom, $urandom};
      if ($urandom_range(1) == 0) x.rt[1:0] = 2'b00;
      x.tv     = ($urandom_range(15) == 0);
      x.tt     = {$urandom, $urandom};
      x.halt   = ($urandom_range(11) == 0);
      x.resume = ($urandom_range(3) == 0);
      apply(x);
      tick();
      $display("rand %0d: pc0=%h pc1=%h v=%0b%0b f=%0b%0b c=%0d/%0d", k, pc0, pc1, valid0, valid1, fault0, fault1, cnt0, cnt1);
      compare_model($sformatf("rand%0d", k));
      if (k % 97 == 96) async_reset($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
